brlite_svc_rx_buffer: RTL and testbench

//  Receive-side buffer between the BrLite router local port and the DMNI NI MMR block.

---
 rtl/brlite_svc_rx_buffer_pkg.sv | 27 ++
 rtl/brlite_svc_rx_buffer_if.sv | 39 +++
 rtl/brlite_svc_rx_buffer_fifo.sv | 71 +++++++
 rtl/brlite_svc_rx_buffer.sv | 76 +++++++
 tb/tb_brlite_svc_rx_buffer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/brlite_svc_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : brlite_svc_rx_buffer_pkg
//  Purpose  : Shared types for the BrLite service receive buffer and the NI.
//  Revision : 1.0 - initial release
// ============================================================================
package brlite_svc_rx_buffer_pkg;

  // BrLite service packet as seen by the router local port and the NI MMR block
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  // Default receive FIFO depth (power of two, >= 2)
  localparam int unsigned BRLITE_SVC_FIFO_DEPTH = 8;

  // Router-side accept handshake: one capture, then one cycle of ack
  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

endpackage
`default_nettype wire

// File: rtl/brlite_svc_rx_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : brlite_svc_rx_buffer_if
//  Purpose  : Router req/ack and NI rx/ack signals of the receive buffer.
//             Signal directions are named from the buffer's point of view.
//  Revision : 1.0 - initial release
// ============================================================================
interface brlite_svc_rx_buffer_if;
  import brlite_svc_rx_buffer_pkg::*;

  logic        br_req_i;
  logic        br_ack_o;
  brlite_svc_t br_data_i;
  logic        br_svc_rx_o;
  brlite_svc_t br_svc_data_o;
  logic        br_svc_ack_i;

  // Buffer side
  modport slave (
    input  br_req_i,
    input  br_data_i,
    input  br_svc_ack_i,
    output br_ack_o,
    output br_svc_rx_o,
    output br_svc_data_o
  );

  // Router + NI side
  modport master (
    output br_req_i,
    output br_data_i,
    output br_svc_ack_i,
    input  br_ack_o,
    input  br_svc_rx_o,
    input  br_svc_data_o
  );

endinterface
`default_nettype wire

// File: rtl/brlite_svc_rx_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : brlite_svc_rx_buffer_fifo
//  Purpose  : Generic synchronous FIFO (storage, pointers, occupancy).
//             Push is ignored when full, pop is ignored when empty.
//             All outputs come straight from registers.
//  Revision : 1.0 - initial release
// ============================================================================
module brlite_svc_rx_buffer_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the pre-edge level, so a pop cannot make room for a same-edge push
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointer/level values; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers; reset clears the storage so the head reads zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/brlite_svc_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : brlite_svc_rx_buffer
//  Purpose  : Receive buffer between the BrLite router local port and the
//             DMNI NI. Captures packets with a req/ack handshake, queues them,
//             and presents the head entry to the NI, which pops with an ack.
//  Revision : 1.0 - initial release
// ============================================================================
module brlite_svc_rx_buffer
  import brlite_svc_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = BRLITE_SVC_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  brlite_svc_rx_buffer_if.slave    bus_if,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);

  hs_state_e state_q;
  logic      ack_q;
  logic      capture;
  logic      fifo_full;
  logic      fifo_empty;

  // A held request is captured only from IDLE, i.e. never in the ack cycle,
  // so a router that keeps req high across ack is not written twice
  assign capture = (state_q == HS_IDLE) && bus_if.br_req_i && !fifo_full;

  // Handshake FSM: IDLE -> ACK (one-cycle registered ack pulse) -> IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (capture) begin
            state_q <= HS_ACK;
            ack_q   <= 1'b1;
          end
        end
        HS_ACK: begin
          state_q <= HS_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= HS_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  brlite_svc_rx_buffer_fifo #(
    .T     (brlite_svc_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (capture),
    .data_i  (bus_if.br_data_i),
    .pop_i   (bus_if.br_svc_ack_i),
    .head_o  (bus_if.br_svc_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign bus_if.br_ack_o    = ack_q;
  assign bus_if.br_svc_rx_o = !fifo_empty;
  assign full_o             = fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_brlite_svc_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_brlite_svc_rx_buffer
//  Purpose  : Self-checking bench for brlite_svc_rx_buffer. A packet-queue
//             reference model predicts captures, acks, occupancy and head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_brlite_svc_rx_buffer;
  import brlite_svc_rx_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] level_o;
  logic       full_o;

  brlite_svc_rx_buffer_if bus ();

  brlite_svc_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .bus_if  (bus),
    .level_o (level_o),
    .full_o  (full_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  brlite_svc_t tx_q[$];    // packets the router still has to deliver
  brlite_svc_t exp_q[$];   // model: packets held by the buffer, oldest first
  bit          m_ackp = 1'b0;
  int          ni_mode = 0;       // 0 idle, 1 pop every cycle, 2 random pops
  int          ni_pulse_req = 0;  // single pop pulse requests from main
  int          ni_pulse_ack = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic brlite_svc_t mk_pkt(input logic [7:0] k, input logic [31:0] pl);
    brlite_svc_t p;
    p.ksvc       = k;
    p.seq_source = 16'($urandom);
    p.producer   = 16'($urandom);
    p.payload    = pl;
    return p;
  endfunction

  // Reference model: a packet is taken when the router requests, there is room,
  // and the previous accept's ack is not in progress; pops need a non-empty buffer
  always @(posedge clk) begin : model
    bit push;
    bit pop;
    if (!rst_ni) begin
      exp_q.delete();
      m_ackp = 1'b0;
    end else begin
      push = bus.br_req_i && (exp_q.size() < DEPTH) && !m_ackp;
      pop  = bus.br_svc_ack_i && (exp_q.size() != 0);
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(bus.br_data_i);
      m_ackp = push;
    end
  end

  // Monitor / scoreboard: compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("ack", 72'(bus.br_ack_o), 72'(m_ackp));
      chk("rx", 72'(bus.br_svc_rx_o), 72'(exp_q.size() != 0));
      chk("level", 72'(level_o), 72'(exp_q.size()));
      chk("full", 72'(full_o), 72'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) chk("head", bus.br_svc_data_o, exp_q[0]);
    end
  end

  // Router driver: holds req and data until ack is seen, then presents the next packet
  always @(negedge clk) begin
    if (rst_ni && bus.br_req_i && bus.br_ack_o && tx_q.size() != 0) void'(tx_q.pop_front());
    if (tx_q.size() != 0) begin
      bus.br_req_i  = 1'b1;
      bus.br_data_i = tx_q[0];
    end else begin
      bus.br_req_i  = 1'b0;
      bus.br_data_i = '0;
    end
  end

  // NI driver: pop pulses
  always @(negedge clk) begin
    if (ni_pulse_req != ni_pulse_ack) begin
      bus.br_svc_ack_i = 1'b1;
      ni_pulse_ack     = ni_pulse_req;
    end else begin
      case (ni_mode)
        1:       bus.br_svc_ack_i = 1'b1;
        2:       bus.br_svc_ack_i = 1'($urandom_range(0, 1));
        default: bus.br_svc_ack_i = 1'b0;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tx(input int budget, input string name);
    int k = 0;
    while (tx_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 72'(tx_q.size()), 72'(0));
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    ni_mode = 1;
    while (level_o != 0 && k < budget) begin
      step(1);
      k++;
    end
    ni_mode = 0;
    step(1);
    chk(name, 72'(level_o), 72'(0));
  endtask

  initial begin : main
    brlite_svc_t p;
    int acks;
    int first_ack;
    int gap;
    int k;
    bit found;

    // Reset values
    step(3);
    chk("rst_ack", 72'(bus.br_ack_o), 72'(0));
    chk("rst_rx", 72'(bus.br_svc_rx_o), 72'(0));
    chk("rst_level", 72'(level_o), 72'(0));
    chk("rst_full", 72'(full_o), 72'(0));
    chk("rst_data", bus.br_svc_data_o, 72'(0));
    rst_ni = 1'b1;

    // Pops while empty are ignored
    ni_mode = 1;
    step(4);
    ni_mode = 0;
    step(1);
    chk("empty_pop_level", 72'(level_o), 72'(0));

    // Single packet, then one NI pop
    p = mk_pkt(8'h2A, 32'hDEADBEEF);
    tx_q.push_back(p);
    wait_tx(20, "single_tx");
    step(1);
    chk("single_rx", 72'(bus.br_svc_rx_o), 72'(1));
    chk("single_payload", 72'(bus.br_svc_data_o.payload), 72'(32'hDEADBEEF));
    chk("single_ksvc", 72'(bus.br_svc_data_o.ksvc), 72'(8'h2A));
    ni_pulse_req++;
    step(2);
    chk("single_popped_rx", 72'(bus.br_svc_rx_o), 72'(0));

    // Fill to DEPTH with a ninth packet pending, free one slot, then drain
    for (int i = 0; i < 9; i++) tx_q.push_back(mk_pkt(8'h30, 32'(i)));
    step(30);
    chk("fill_full", 72'(full_o), 72'(1));
    chk("fill_level", 72'(level_o), 72'(DEPTH));
    chk("fill_pending", 72'(tx_q.size()), 72'(1));
    chk("fill_no_ack", 72'(bus.br_ack_o), 72'(0));
    ni_pulse_req++;
    wait_tx(10, "fill_ninth_tx");
    step(1);
    chk("fill_refull", 72'(full_o), 72'(1));
    chk("fill_head", 72'(bus.br_svc_data_o.payload), 72'(32'd1));
    drain(40, "fill_drain");

    // Simultaneous push and pop at level 3
    for (int i = 0; i < 3; i++) tx_q.push_back(mk_pkt(8'h40, 32'h40 + 32'(i)));
    wait_tx(20, "sim_fill_tx");
    step(1);
    chk("sim_pre_level", 72'(level_o), 72'(3));
    tx_q.push_back(mk_pkt(8'h40, 32'h43));
    ni_pulse_req++;
    wait_tx(10, "sim_tx");
    chk("sim_level", 72'(level_o), 72'(3));
    chk("sim_head", 72'(bus.br_svc_data_o.payload), 72'(32'h41));
    drain(20, "sim_drain");

    // Back-to-back A, B with req held across the ack
    tx_q.push_back(mk_pkt(8'hA0, 32'hAAAA_0001));
    tx_q.push_back(mk_pkt(8'hB0, 32'hBBBB_0002));
    acks = 0;
    first_ack = 0;
    gap = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (bus.br_ack_o) begin
        if (acks == 0) first_ack = c;
        else gap = c - first_ack;
        acks++;
      end
    end
    chk("b2b_acks", 72'(acks), 72'(2));
    chk("b2b_gap", 72'(gap), 72'(2));
    chk("b2b_level", 72'(level_o), 72'(2));
    drain(20, "b2b_drain");

    // Asynchronous reset at level 5 with an ack in flight
    for (int i = 0; i < 6; i++) tx_q.push_back(mk_pkt(8'h60, 32'h60 + 32'(i)));
    found = 1'b0;
    k = 0;
    while (!found && k < 60) begin
      @(posedge clk);
      #1;
      if (bus.br_ack_o && level_o == 4'd5) found = 1'b1;
      k++;
    end
    chk("rst_mid_reached", 72'(found), 72'(1));
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ack", 72'(bus.br_ack_o), 72'(0));
    chk("rst_mid_rx", 72'(bus.br_svc_rx_o), 72'(0));
    chk("rst_mid_level", 72'(level_o), 72'(0));
    chk("rst_mid_full", 72'(full_o), 72'(0));
    chk("rst_mid_data", bus.br_svc_data_o, 72'(0));
    step(2);
    rst_ni = 1'b1;
    wait_tx(20, "rst_mid_tx");
    step(1);
    chk("rst_mid_relevel", 72'(level_o), 72'(2));
    chk("rst_mid_head", 72'(bus.br_svc_data_o.payload), 72'(32'h64));
    drain(20, "rst_mid_drain");

    // Randomized traffic with random NI pops
    for (int i = 0; i < 60; i++) tx_q.push_back(mk_pkt(8'($urandom), $urandom));
    ni_mode = 2;
    wait_tx(2000, "rand_tx");
    drain(100, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
